// File: rtl/max7317_pkg.sv
// Shared constants, state encoding and register-map helpers for the MAX7317 port-expander emulator.
package max7317_pkg;

   localparam int FRAME_W = 16;

   localparam logic [6:0] ADDR_P0       = 7'h00;
   localparam logic [6:0] ADDR_P1       = 7'h01;
   localparam logic [6:0] ADDR_P2       = 7'h02;
   localparam logic [6:0] ADDR_P3       = 7'h03;
   localparam logic [6:0] ADDR_P4       = 7'h04;
   localparam logic [6:0] ADDR_P5       = 7'h05;
   localparam logic [6:0] ADDR_P6       = 7'h06;
   localparam logic [6:0] ADDR_P7       = 7'h07;
   localparam logic [6:0] ADDR_P8       = 7'h08;
   localparam logic [6:0] ADDR_P9       = 7'h09;
   localparam logic [6:0] ADDR_ALL      = 7'h0A;
   localparam logic [6:0] ADDR_P3_P0    = 7'h0B;
   localparam logic [6:0] ADDR_P7_P4    = 7'h0C;
   localparam logic [6:0] ADDR_RSVD     = 7'h0D;
   localparam logic [6:0] ADDR_IN_P7_P0 = 7'h0E;
   localparam logic [6:0] ADDR_IN_P9_P8 = 7'h0F;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_EXEC   = 2'd2
   } state_e;

   // Pin level seen by the device is the wired-AND of its own latch and the external level.
   function automatic logic [7:0] read_data(input logic [6:0] addr,
                                            input logic [9:0] p_out,
                                            input logic [9:0] p_in);
      logic [9:0] lvl;
      lvl = p_out & p_in;
      case (addr)
         ADDR_IN_P7_P0: read_data = lvl[7:0];
         ADDR_IN_P9_P8: read_data = {6'b000000, lvl[9:8]};
         default:       read_data = 8'h00;
      endcase
   endfunction

   function automatic logic [9:0] apply_write(input logic [6:0] addr,
                                              input logic       d0,
                                              input logic [9:0] p_out);
      apply_write = p_out;
      if (addr <= ADDR_P9) begin
         apply_write[addr[3:0]] = d0;
      end else begin
         case (addr)
            ADDR_ALL:   apply_write      = {10{d0}};
            ADDR_P3_P0: apply_write[3:0] = {4{d0}};
            ADDR_P7_P4: apply_write[7:4] = {4{d0}};
            default:    apply_write      = p_out;
         endcase
      end
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with single-cycle rise/fall pulses.
module sync_edge #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [2:0] sh_q;
   logic [2:0] sh_d;

   // Shift the raw input through two metastability flops plus one history flop.
   always_comb begin
      sh_d = {sh_q[1:0], d};
   end

   // Synchronizer state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sh_q <= {3{RESET_VAL}};
      end else begin
         sh_q <= sh_d;
      end
   end

   assign rise = sh_q[1] & ~sh_q[2];
   assign fall = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/max7317_emulator.sv
// MAX7317-style SPI port expander: oversampled mode-0 slave driving ten open-drain port latches.
module max7317_emulator
   import max7317_pkg::*;
#(
   parameter logic [9:0] RESET_PORTS = 10'h3FF,
   parameter int          MIN_RATIO   = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       sclk,
   input  logic       CSn,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic [9:0] P_in,
   output logic [9:0] P_out,
   output logic [7:0] frame_cnt,
   output logic [3:0] short_cnt
);

   // Edge detection behind a 2-flop synchronizer needs at least two clk samples per sclk phase.
   if (MIN_RATIO < 4) begin : g_ratio_chk
      $error("max7317_emulator: MIN_RATIO below 4 is not supported");
   end

   localparam logic [4:0] BIT_FULL = 5'(FRAME_W);

   logic sclk_rise_s, sclk_fall_s, csn_rise_s, csn_fall_s;

   state_e               state_q,     state_d;
   logic [FRAME_W-1:0]   shift_in_q,  shift_in_d;
   logic [FRAME_W-1:0]   shift_out_q, shift_out_d;
   logic [FRAME_W-1:0]   resp_q,      resp_d;
   logic [4:0]           bit_cnt_q,   bit_cnt_d;
   logic [9:0]           p_out_q,     p_out_d;
   logic [7:0]           frame_cnt_q, frame_cnt_d;
   logic [3:0]           short_cnt_q, short_cnt_d;
   logic                 miso_q,      miso_d;
   logic                 miso_oe_q,   miso_oe_d;
   logic [1:0]           mosi_sync_q, mosi_sync_d;
   logic [6:0]           cmd_addr_s;

   sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
      .clk  (clk),
      .rstn (rstn),
      .d    (sclk),
      .rise (sclk_rise_s),
      .fall (sclk_fall_s)
   );

   sync_edge #(.RESET_VAL(1'b1)) u_sync_csn (
      .clk  (clk),
      .rstn (rstn),
      .d    (CSn),
      .rise (csn_rise_s),
      .fall (csn_fall_s)
   );

   assign cmd_addr_s = shift_in_q[14:8];

   // Frame sequencing, shifting and command execution.
   always_comb begin
      state_d     = state_q;
      shift_in_d  = shift_in_q;
      shift_out_d = shift_out_q;
      resp_d      = resp_q;
      bit_cnt_d   = bit_cnt_q;
      p_out_d     = p_out_q;
      frame_cnt_d = frame_cnt_q;
      short_cnt_d = short_cnt_q;
      miso_d      = miso_q;
      miso_oe_d   = miso_oe_q;
      mosi_sync_d = {mosi_sync_q[0], mosi};
      case (state_q)
         ST_IDLE: begin
            if (csn_fall_s) begin
               state_d     = ST_SELECT;
               shift_out_d = resp_q;
               miso_d      = resp_q[FRAME_W-1];
               miso_oe_d   = 1'b1;
               bit_cnt_d   = 5'd0;
            end else begin
               miso_d    = 1'b0;
               miso_oe_d = 1'b0;
            end
         end
         ST_SELECT: begin
            if (csn_rise_s) begin
               miso_d    = 1'b0;
               miso_oe_d = 1'b0;
               if (bit_cnt_q >= BIT_FULL) begin
                  state_d = ST_EXEC;
               end else begin
                  state_d     = ST_IDLE;
                  short_cnt_d = (short_cnt_q == 4'hF) ? 4'hF : short_cnt_q + 4'd1;
               end
            end else if (sclk_rise_s) begin
               // Keeps shifting past 16 bits so the final 16 sampled bits form the command.
               shift_in_d = {shift_in_q[FRAME_W-2:0], mosi_sync_q[1]};
               bit_cnt_d  = (bit_cnt_q == BIT_FULL) ? BIT_FULL : bit_cnt_q + 5'd1;
            end else if (sclk_fall_s) begin
               shift_out_d = {shift_out_q[FRAME_W-2:0], 1'b0};
               miso_d      = shift_out_q[FRAME_W-2];
            end else begin
               state_d = ST_SELECT;
            end
         end
         ST_EXEC: begin
            state_d     = ST_IDLE;
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (shift_in_q[FRAME_W-1]) begin
               resp_d = {shift_in_q[15:8], read_data(cmd_addr_s, p_out_q, P_in)};
            end else begin
               resp_d  = shift_in_q;
               p_out_d = apply_write(cmd_addr_s, shift_in_q[0], p_out_q);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         shift_in_q  <= '0;
         shift_out_q <= '0;
         resp_q      <= 16'h0000;
         bit_cnt_q   <= 5'd0;
         p_out_q     <= RESET_PORTS;
         frame_cnt_q <= 8'd0;
         short_cnt_q <= 4'd0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
         mosi_sync_q <= 2'b00;
      end else begin
         state_q     <= state_d;
         shift_in_q  <= shift_in_d;
         shift_out_q <= shift_out_d;
         resp_q      <= resp_d;
         bit_cnt_q   <= bit_cnt_d;
         p_out_q     <= p_out_d;
         frame_cnt_q <= frame_cnt_d;
         short_cnt_q <= short_cnt_d;
         miso_q      <= miso_d;
         miso_oe_q   <= miso_oe_d;
         mosi_sync_q <= mosi_sync_d;
      end
   end

   assign miso      = miso_q;
   assign miso_oe   = miso_oe_q;
   assign P_out     = p_out_q;
   assign frame_cnt = frame_cnt_q;
   assign short_cnt = short_cnt_q;

endmodule

// File: tb/tb_max7317_emulator.sv
// Directed plus randomized SPI frames against a behavioural port-expander model.
`timescale 1ns/1ps
module tb_max7317_emulator;

   logic       clk = 1'b0;
   logic       rstn, sclk, CSn, mosi;
   logic       miso, miso_oe;
   logic [9:0] P_in, P_out;
   logic [7:0] frame_cnt;
   logic [3:0] short_cnt;

   int checks = 0;
   int errors = 0;

   logic [9:0]  m_pout;
   logic [15:0] m_resp;
   logic [7:0]  m_frame;
   logic [3:0]  m_short;

   max7317_emulator #(.RESET_PORTS(10'h3FF), .MIN_RATIO(4)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .sclk      (sclk),
      .CSn       (CSn),
      .mosi      (mosi),
      .miso      (miso),
      .miso_oe   (miso_oe),
      .P_in      (P_in),
      .P_out     (P_out),
      .frame_cnt (frame_cnt),
      .short_cnt (short_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pout  = 10'h3FF;
      m_resp  = 16'h0000;
      m_frame = 8'd0;
      m_short = 4'd0;
   endtask

   // Device behaviour from the register map: reads report latch AND pin, writes set port groups.
   task automatic model_frame(input logic [31:0] word, input int nbits);
      logic [15:0] cmd;
      logic [7:0]  rd;
      logic        lvl;
      int          addr;
      if (nbits < 16) begin
         if (m_short != 4'hF) m_short = m_short + 4'd1;
         return;
      end
      cmd  = word[15:0];
      addr = int'(cmd[14:8]);
      if (cmd[15]) begin
         rd = 8'h00;
         for (int i = 0; i < 10; i++) begin
            lvl = m_pout[i] & P_in[i];
            if (addr == 14 && i < 8) rd[i] = lvl;
            if (addr == 15 && i >= 8) rd[i-8] = lvl;
         end
         m_resp = {cmd[15:8], rd};
      end else begin
         for (int i = 0; i < 10; i++) begin
            if (addr == i || addr == 10 || (addr == 11 && i < 4) || (addr == 12 && i >= 4 && i < 8))
               m_pout[i] = cmd[0];
         end
         m_resp = cmd;
      end
      m_frame = m_frame + 8'd1;
   endtask

   // Mode-0 master, sclk = clk/8; rst_at >= 0 pulses rstn before that bit and abandons the frame.
   task automatic spi_frame(input logic [31:0] word, input int nbits, input int rst_at,
                            output logic [31:0] rx);
      rx = 32'd0;
      @(negedge clk);
      CSn = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = nbits - 1; i >= 0; i--) begin
         if ((nbits - 1 - i) == rst_at) begin
            rstn = 1'b0;
            repeat (2) @(negedge clk);
            CSn  = 1'b1;
            sclk = 1'b0;
            mosi = 1'b0;
            repeat (2) @(negedge clk);
            rstn = 1'b1;
            repeat (4) @(negedge clk);
            return;
         end
         mosi = word[i];
         repeat (4) @(negedge clk);
         sclk = 1'b1;
         rx = {rx[30:0], miso};
         if (i == nbits - 1) check("miso_oe_selected", 32'(miso_oe), 32'd1);
         repeat (4) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (4) @(negedge clk);
      CSn  = 1'b1;
      mosi = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic frame(input logic [31:0] word, input int nbits, output logic [31:0] rx);
      logic [31:0] exp;
      exp = (nbits >= 16) ? (32'(m_resp) << (nbits - 16)) : (32'(m_resp) >> (16 - nbits));
      spi_frame(word, nbits, -1, rx);
      check("miso_word", rx, exp);
      model_frame(word, nbits);
      check("p_out", 32'(P_out), 32'(m_pout));
      check("frame_cnt", 32'(frame_cnt), 32'(m_frame));
      check("short_cnt", 32'(short_cnt), 32'(m_short));
      check("miso_oe_idle", 32'(miso_oe), 32'd0);
   endtask

   initial begin
      logic [31:0] rx;
      logic [15:0] cmd;
      logic [7:0]  fc_before;
      int          addr, nbits, r;

      rstn = 1'b1; sclk = 1'b0; CSn = 1'b1; mosi = 1'b0; P_in = 10'h000;
      model_reset();
      @(negedge clk);
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_p_out", 32'(P_out), 32'h3FF);
      check("rst_miso", 32'(miso), 32'd0);
      check("rst_miso_oe", 32'(miso_oe), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_short_cnt", 32'(short_cnt), 32'd0);
      rstn = 1'b1;
      repeat (3) @(negedge clk);

      frame(32'h0A01, 16, rx);
      frame(32'h0200, 16, rx);
      check("echo_write", rx, 32'h0A01);
      check("p2_low", 32'(P_out), 32'h3FB);

      frame(32'h0A01, 16, rx);
      P_in = 10'h255;
      frame(32'h8E00, 16, rx);
      frame(32'h0200, 16, rx);
      check("read_p7_p0", rx, 32'h8E55);

      P_in = 10'h200;
      frame(32'h0B00, 16, rx);
      check("p3_p0_low", 32'(P_out[3:0]), 32'h0);
      frame(32'h8F00, 16, rx);
      frame(32'h0D00, 16, rx);
      check("read_p9_p8", rx, 32'h8F02);

      fc_before = frame_cnt;
      frame(32'h0C00 >> 7, 9, rx);
      check("abort_short_cnt", 32'(short_cnt), 32'd1);
      check("abort_frame_cnt", 32'(frame_cnt), 32'(fc_before));
      frame(32'h0200, 16, rx);
      check("abort_keeps_resp", rx, 32'h0D00);

      fc_before = frame_cnt;
      frame(32'h0500, 16, rx);
      frame(32'h30501, 18, rx);
      check("long_frame_p5", 32'(P_out[5]), 32'd1);
      check("long_frame_cnt", 32'(frame_cnt - fc_before), 32'd2);

      spi_frame(32'h0C00, 16, 7, rx);
      model_reset();
      frame(32'h0200, 16, rx);
      check("midrst_miso", rx, 32'h0000);
      check("midrst_p_out", 32'(P_out), 32'h3FB);
      check("midrst_frame_cnt", 32'(frame_cnt), 32'd1);

      for (int i = 0; i < 6; i++) begin
         mosi = 1'($urandom_range(0, 1));
         sclk = 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
         repeat (4) @(negedge clk);
      end
      mosi = 1'b0;
      check("idle_sclk_p_out", 32'(P_out), 32'(m_pout));
      check("idle_sclk_frame_cnt", 32'(frame_cnt), 32'(m_frame));
      frame(32'h0A00, 16, rx);

      for (int i = 0; i < 17; i++) frame(32'h5, 3, rx);
      check("short_cnt_saturated", 32'(short_cnt), 32'hF);

      for (int i = 0; i < 40; i++) begin
         P_in  = 10'($urandom);
         addr  = int'($urandom_range(0, 16));
         cmd   = {1'($urandom_range(0, 1)), 7'(addr), 8'($urandom)};
         r     = int'($urandom_range(0, 9));
         nbits = (r == 0) ? int'($urandom_range(4, 15)) : (r == 1) ? int'($urandom_range(17, 20)) : 16;
         frame({16'($urandom), cmd}, nbits, rx);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/max7317_emulator.md
MAX7317_EMULATOR -- requirements
Module: max7317_emulator

Interface
REQ-001 SHALL have parameter RESET_PORTS, default 10'h3FF, giving the port latch value after reset (1 = high-Z/input).
REQ-002 SHALL have parameter MIN_RATIO, default 4, giving the minimum clk/sclk frequency ratio supported; it is documentation/assertion only.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 sclk  input  1  SPI clock from the master, asynchronous to clk.
REQ-006 CSn  input  1  SPI chip select from the master, active low.
REQ-007 mosi  input  1  SPI data from the master, MSB (D15) first.
REQ-008 miso  output  1  SPI data to the master.
REQ-009 miso_oe  output  1  high while the frame is selected (synchronized CSn low); top level tri-states miso otherwise.
REQ-010 P_in  input  10  external pin levels for ports P9..P0.
REQ-011 P_out  output  10  port latches; 1 = high-Z, 0 = drive low.
REQ-012 frame_cnt  output  8  count of completed valid frames, wraps.
REQ-013 short_cnt  output  4  count of aborted frames (<16 bits), saturates at 4'hF.

Function
REQ-014 SHALL pass sclk, CSn and mosi through 2-flop synchronizers, then detect edges on the synchronized sclk and CSn.
REQ-015 SHALL sample mosi on the synchronized sclk rising edge into a 16-bit shift-in register, MSB first, and shift miso out on the falling edge (SPI mode 0).
REQ-016 States: IDLE, SELECT, EXEC. IDLE->SELECT on the CSn falling edge; SELECT->EXEC on the CSn rising edge with bit_cnt>=16; SELECT->IDLE on the CSn rising edge with bit_cnt<16; EXEC->IDLE after exactly 1 cycle.
REQ-017 On entry to SELECT: load the shift-out register with resp, drive miso = resp[15] in the same cycle, and clear bit_cnt.
REQ-018 bit_cnt SHALL be 5 bits and saturate at 16; with more than 16 bits, the last 16 sampled bits form the command.
REQ-019 In EXEC: decode the command, update P_out, set resp, and increment frame_cnt modulo 256.
REQ-020 resp SHALL normally equal the command just received.
REQ-021 When the command is a read (D15=1), resp[7:0] SHALL be replaced with the read data sampled in the EXEC cycle.
REQ-022 Address 0x0E read SHALL return, for ports P7..P0, P_out[i] & P_in[i].
REQ-023 Address 0x0F read SHALL return {6'b0, P_out[9]&P_in[9], P_out[8]&P_in[8]}.
REQ-024 Any other read address SHALL return 8'h00 in resp[7:0].
REQ-025 Write addresses, applied in EXEC with value = D0:
  - 0x00-0x09: P_out[addr] <= D0.
  - 0x0A: all P9..P0 <= D0.
  - 0x0B: P3..P0 <= D0.
  - 0x0C: P7..P4 <= D0.
  - 0x0D, 0x0E, 0x0F (write), 0x10-0x7F: no-op (resp is still updated).
REQ-026 An aborted frame (<16 bits) SHALL change no port, leave resp unchanged, increment short_cnt (saturating), and not increment frame_cnt.
REQ-027 A CSn falling edge in the EXEC cycle cannot occur; a CSn falling edge in IDLE within 1 cycle of EXEC SHALL still load the updated resp.
REQ-028 Sclk edges while CSn is high SHALL be ignored.
REQ-029 When not selected, miso SHALL be 0 and miso_oe SHALL be 0.
REQ-030 Correct operation is required only for clk >= MIN_RATIO x sclk, with CSn setup/hold of at least 2 clk periods.

Reset
REQ-031 On rstn low, SHALL asynchronously set:
  - state IDLE; P_out = RESET_PORTS; resp = 16'h0000.
  - bit_cnt, frame_cnt and short_cnt = 0.
  - miso = 0; miso_oe = 0.
  - synchronizer flops: CSn path = 1, others = 0.
REQ-032 Reset asserted mid-frame SHALL discard the frame; after release, the next frame starts only at a fresh CSn falling edge.

Structure
REQ-033 Package max7317_pkg SHALL hold the address constants (0x00-0x0F), the state enum, and the 16-bit frame width constant.
REQ-034 SHALL instantiate sub-module sync_edge (2-flop synchronizer plus rise/fall pulse outputs), one instance each for sclk and CSn; mosi uses the synchronizer only.

Verification
REQ-035 After reset, send 0x0A01 then 0x0200 -> second frame's miso = 0x0A01; P_out = 10'h3FB (P2 low).
REQ-036 With P_in = 10'h255 and P_out = 10'h3FF, send 0x8E00 then 0x0200 -> second frame's miso = 0x8E55.
REQ-037 Send 0x0B00 then 0x8F00 then a NOP frame, with P_in[9:8] = 2'b10 -> P_out[3:0] = 0; third frame's miso = 0x8F02.
REQ-038 Raise CSn after 9 bits of 0x0C00 -> P_out unchanged, short_cnt = 1, frame_cnt unchanged, next frame's miso = previous resp.
REQ-039 Send 18 bits with the last 16 = 0x0501 after a 0x0500 frame -> P_out[5] = 1, frame_cnt increments by 2 total.
REQ-040 Assert rstn low mid-frame (bit 7), then release and send 0x0200 -> miso = 0x0000, P_out = 10'h3FB, frame_cnt = 1.
